// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-entry busy scoreboard.
// After reset the array is cleared by a one-entry-per-cycle sweep; outputs are
// held at zero and traffic is ignored until the sweep reaches the last entry.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_RA_addr,
    input  logic [ADDR_W-1:0] i_RB_addr,
    output logic [DATA_W-1:0] o_BusA_data,
    output logic [DATA_W-1:0] o_BusB_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_RW_addr,
    input  logic [DATA_W-1:0] i_BusW_data,
    input  logic              i_alloc,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    output logic              o_A_busy,
    output logic              o_B_busy,
    output logic              o_ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   ptr_q;
    logic [ADDR_W:0]   ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              running;
    logic              wr_en;
    logic              alloc_en;
    logic [DATA_W:0]   port_a;
    logic [DATA_W:0]   port_b;

    // Read mux for one port, result packed as {busy, data}. Entry 0 masking
    // takes priority over forwarding so a write to r0 never leaks through.
    function automatic logic [DATA_W:0] read_port(
        input logic              run,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              stored_busy,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W:0] res;
        res = '0;
        if (!run) begin
            res = '0;
        end else if (ZERO_REG != 0 && addr == '0) begin
            res = '0;
        end else if (BYPASS != 0 && we && waddr == addr) begin
            res = {1'b0, wdata};
        end else begin
            res = {stored_busy, stored};
        end
        return res;
    endfunction

    assign running  = (state_q == S_RUN);
    assign wr_en    = running && i_we &&
                      !(ZERO_REG != 0 && i_RW_addr == '0);
    assign alloc_en = running && i_alloc &&
                      !(ZERO_REG != 0 && i_alloc_addr == '0);

    // Sequencer next state: reset restarts the sweep, the sweep ends at DEPTH-1.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (i_rst) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
    end

    // Storage: zeroed by the sweep, written by i_we once running; untouched on the reset edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_q == S_CLEAR) begin
                mem[ptr_q[ADDR_W-1:0]] <= '0;
            end else if (wr_en) begin
                mem[i_RW_addr] <= i_BusW_data;
            end
        end
    end

    // Scoreboard update: a write retires the producer, an alloc applied last so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[i_RW_addr] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[i_alloc_addr] = 1'b1;
        end
    end

    // Scoreboard register, cleared in a single cycle on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read port A.
    always_comb begin
        port_a = read_port(running, i_RA_addr, mem[i_RA_addr], busy_q[i_RA_addr],
                           i_we, i_RW_addr, i_BusW_data);
    end

    // Read port B.
    always_comb begin
        port_b = read_port(running, i_RB_addr, mem[i_RB_addr], busy_q[i_RB_addr],
                           i_we, i_RW_addr, i_BusW_data);
    end

    assign o_BusA_data = port_a[DATA_W-1:0];
    assign o_A_busy    = port_a[DATA_W];
    assign o_BusB_data = port_b[DATA_W-1:0];
    assign o_B_busy    = port_b[DATA_W];
    assign o_ready     = running;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances share one stimulus set,
// default (ZERO_REG=1, BYPASS=1), no forwarding, and no hardwired zero.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        we;
    logic [4:0]  rw_addr;
    logic [31:0] wdata;
    logic        alloc;
    logic [4:0]  alloc_addr;

    logic [31:0] a_data,  b_data,  a_data_nb, b_data_nb, a_data_nz, b_data_nz;
    logic        a_busy,  b_busy,  a_busy_nb, b_busy_nb, a_busy_nz, b_busy_nz;
    logic        ready,   ready_nb, ready_nz;

    int n_pass  = 0;
    int n_total = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_RA_addr(ra_addr), .i_RB_addr(rb_addr),
        .o_BusA_data(a_data), .o_BusB_data(b_data), .i_we(we), .i_RW_addr(rw_addr),
        .i_BusW_data(wdata), .i_alloc(alloc), .i_alloc_addr(alloc_addr),
        .o_A_busy(a_busy), .o_B_busy(b_busy), .o_ready(ready)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .i_clk(clk), .i_rst(rst), .i_RA_addr(ra_addr), .i_RB_addr(rb_addr),
        .o_BusA_data(a_data_nb), .o_BusB_data(b_data_nb), .i_we(we), .i_RW_addr(rw_addr),
        .i_BusW_data(wdata), .i_alloc(alloc), .i_alloc_addr(alloc_addr),
        .o_A_busy(a_busy_nb), .o_B_busy(b_busy_nb), .o_ready(ready_nb)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u_nozero (
        .i_clk(clk), .i_rst(rst), .i_RA_addr(ra_addr), .i_RB_addr(rb_addr),
        .o_BusA_data(a_data_nz), .o_BusB_data(b_data_nz), .i_we(we), .i_RW_addr(rw_addr),
        .i_BusW_data(wdata), .i_alloc(alloc), .i_alloc_addr(alloc_addr),
        .o_A_busy(a_busy_nz), .o_B_busy(b_busy_nz), .o_ready(ready_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; alloc = 1'b0;
    endtask

    // Any nonzero output or ready while the sweep runs.
    function automatic bit leaking();
        return (a_data != 0) || (b_data != 0) || a_busy || b_busy || ready ||
               (a_data_nb != 0) || (a_data_nz != 0) || a_busy_nz || ready_nz;
    endfunction

    // Count edges from reset release until ready, flagging leaks; traffic at edge 10 must be ignored.
    task automatic run_sweep(input bit with_traffic, output int edges, output bit leak);
        edges = 0;
        leak  = 1'b0;
        while (edges < 64) begin
            if (with_traffic && edges == 9) begin
                we = 1'b1; rw_addr = 5'd3; wdata = 32'hAA;
                alloc = 1'b1; alloc_addr = 5'd3;
            end
            tick();
            idle();
            edges++;
            #1;
            if (ready) break;
            if (leaking()) leak = 1'b1;
        end
    endtask

    int edges;
    bit leak;

    initial begin
        rst = 1'b1; ra_addr = '0; rb_addr = '0; we = 1'b0; rw_addr = '0;
        wdata = '0; alloc = 1'b0; alloc_addr = '0;

        // Reset values.
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busA", a_data, 32'd0);
        check("rst_busB", b_data, 32'd0);
        check("rst_busy", {30'b0, a_busy, b_busy}, 32'd0);

        // Sweep latency after a one-edge reset pulse.
        rst = 1'b0;
        run_sweep(1'b0, edges, leak);
        check("sweep_latency", edges, 32'd32);
        check("sweep_leak", {31'b0, leak}, 32'd0);
        check("ready_all", {29'b0, ready, ready_nb, ready_nz}, 32'h7);

        // Every entry reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            ra_addr = 5'(i); rb_addr = 5'(31 - i);
            #1;
            check($sformatf("clr_A%0d", i), a_data_nz, 32'd0);
            check($sformatf("clr_B%0d", i), b_data, 32'd0);
        end

        // Same-cycle write and read of entry 5.
        we = 1'b1; rw_addr = 5'd5; wdata = 32'hDEADBEEF; ra_addr = 5'd5;
        #1;
        check("byp_same", a_data, 32'hDEADBEEF);
        check("nobyp_same", a_data_nb, 32'd0);
        tick();
        idle();
        #1;
        check("byp_next", a_data, 32'hDEADBEEF);
        check("nobyp_next", a_data_nb, 32'hDEADBEEF);

        // Write and alloc entry 0.
        we = 1'b1; rw_addr = 5'd0; wdata = 32'h12345678;
        alloc = 1'b1; alloc_addr = 5'd0; ra_addr = 5'd0;
        tick();
        idle();
        #1;
        check("r0_data", a_data, 32'd0);
        check("r0_busy", {31'b0, a_busy}, 32'd0);
        check("r0_nz_data", a_data_nz, 32'h12345678);
        check("r0_nz_busy", {31'b0, a_busy_nz}, 32'd1);

        // Scoreboard on entry 7.
        rb_addr = 5'd7; alloc = 1'b1; alloc_addr = 5'd7;
        #1;
        check("alloc7_same", {31'b0, b_busy}, 32'd0);
        tick();
        idle();
        #1;
        check("alloc7_next", {31'b0, b_busy}, 32'd1);
        check("alloc7_nb", {31'b0, b_busy_nb}, 32'd1);
        we = 1'b1; rw_addr = 5'd7; wdata = 32'h55;
        #1;
        check("wr7_busy_byp", {31'b0, b_busy}, 32'd0);
        check("wr7_data_byp", b_data, 32'h55);
        check("wr7_busy_nb", {31'b0, b_busy_nb}, 32'd1);
        check("wr7_data_nb", b_data_nb, 32'd0);
        tick();
        idle();
        #1;
        check("wr7_after", {31'b0, b_busy_nb}, 32'd0);
        check("wr7_after_d", b_data_nb, 32'h55);

        // Alloc and write of entry 9 together: new producer wins.
        ra_addr = 5'd9; we = 1'b1; rw_addr = 5'd9; wdata = 32'h99;
        alloc = 1'b1; alloc_addr = 5'd9;
        #1;
        check("ab9_same_busy", {31'b0, a_busy}, 32'd0);
        tick();
        idle();
        #1;
        check("ab9_busy", {31'b0, a_busy}, 32'd1);
        check("ab9_data", a_data, 32'h99);

        // Put a nonzero value at the last entry to watch for leaks during the next sweep.
        we = 1'b1; rw_addr = 5'd31; wdata = 32'hCAFE0001;
        tick();
        idle();
        ra_addr = 5'd31; rb_addr = 5'd9;
        #1;
        check("r31_data", a_data, 32'hCAFE0001);

        // Reset from RUN, abort the sweep at edge 20, then a clean sweep with ignored traffic.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        leak = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (leaking()) leak = 1'b1;
        end
        check("abort_leak", {31'b0, leak}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra_addr = 5'd3; rb_addr = 5'd31;
        run_sweep(1'b1, edges, leak);
        check("restart_latency", edges, 32'd32);
        check("restart_leak", {31'b0, leak}, 32'd0);
        check("ign3_data", a_data_nz, 32'd0);
        check("ign3_busy", {30'b0, a_busy, a_busy_nz}, 32'd0);
        check("r31_cleared", b_data, 32'd0);
        rb_addr = 5'd9;
        #1;
        check("busy9_cleared", {31'b0, b_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a built-in busy scoreboard for the pipelined datapath. It generalises the single-cycle 32x32 register file:
- width and depth are configurable;
- register 0 is optionally hardwired to zero;
- writes can be forwarded to the read ports in the same cycle;
- each register carries a busy bit so hazard logic can stall on pending producers;
- reset clears the array with a sequential sweep, one entry per cycle.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- ZERO_REG, 1, 1: entry 0 reads as 0, ignores writes and allocs
- BYPASS, 1, 1: same-cycle write data forwarded to matching read port

Ports (one clock, i_clk; reset i_rst is synchronous, active-high):
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset, starts clear sweep
- i_RA_addr  in  ADDR_W  read port A address
- i_RB_addr  in  ADDR_W  read port B address
- o_BusA_data  out  DATA_W  port A data, combinational
- o_BusB_data  out  DATA_W  port B data, combinational
- i_we  in  1  write enable
- i_RW_addr  in  ADDR_W  write address
- i_BusW_data  in  DATA_W  write data
- i_alloc  in  1  mark i_alloc_addr busy (producer issued)
- i_alloc_addr  in  ADDR_W  register being allocated
- o_A_busy  out  1  port A register has pending producer
- o_B_busy  out  1  port B register has pending producer
- o_ready  out  1  clear sweep finished, block accepts traffic

## Operation
State machine: CLEAR, RUN.
- Reset edge (i_rst=1):
  - state<=CLEAR, ptr<=0.
  - All busy bits <=0 in one cycle.
  - Memory untouched on this edge.
- CLEAR:
  - Each edge with i_rst=0 writes 0 to mem[ptr] and increments ptr.
  - On the edge that clears entry DEPTH-1, state<=RUN.
  - i_we and i_alloc are ignored.
  - o_BusA_data, o_BusB_data, o_A_busy and o_B_busy are forced to 0.
  - o_ready=0.
- RUN:
  - o_ready=1.
  - If i_we, mem[i_RW_addr]<=i_BusW_data and busy[i_RW_addr]<=0.
  - If i_alloc, busy[i_alloc_addr]<=1.
- Alloc and write on the same address in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Read, per port P in {A,B}:
  - If ZERO_REG and addr==0: data 0, busy 0.
  - Else if BYPASS and i_we and i_RW_addr==addr: data=i_BusW_data, busy 0.
  - Else data=mem[addr], busy=busy[addr].
- ZERO_REG=1:
  - Writes to entry 0 are dropped.
  - Allocs to entry 0 are dropped.
  - busy[0] is held at 0.
- ZERO_REG=0: entry 0 behaves like any other entry.
- Ptr is ADDR_W+1 bits wide. No wrap: the sweep ends exactly at DEPTH-1.

## Timing
- Reset values:
  - o_ready=0.
  - o_BusA_data=o_BusB_data=0.
  - o_A_busy=o_B_busy=0.
  - All busy bits 0.
- Clear latency: with i_rst high for one edge, o_ready rises exactly DEPTH cycles after i_rst falls. For DEPTH=32 this is 32 cycles.
- Reset asserted mid-sweep or during RUN restarts the sweep from ptr=0. Partially cleared data is never exposed, because outputs are forced to 0 until RUN.
- Read latency: 0 cycles (combinational from address).
- Write visibility:
  - Next cycle with BYPASS=0.
  - Same cycle with BYPASS=1.
- Busy set by alloc is visible the cycle after the alloc edge. Busy cleared by a write is masked the same cycle when BYPASS=1.
- No handshake on writes: every i_we in RUN is accepted.

## Test plan
- Reset sweep: pulse i_rst 1 cycle, DEPTH=32 -> o_ready low for exactly 32 cycles then high. Read all 32 addresses -> 0.
- Write/read with BYPASS=1: i_we, RW=5, data 0xDEADBEEF, RA=5 the same cycle -> o_BusA_data=0xDEADBEEF that cycle and after. Repeat with BYPASS=0 -> old value (0) that cycle, 0xDEADBEEF next.
- Zero register, ZERO_REG=1: write 0x12345678 to addr 0, alloc addr 0 -> RA=0 reads 0 and o_A_busy=0. With ZERO_REG=0 -> reads 0x12345678.
- Scoreboard:
  - Alloc addr 7 -> o_B_busy=1 (RB=7) from the next cycle.
  - Write addr 7 data 0x55 -> o_B_busy=0 that cycle (BYPASS=1), data 0x55.
  - Same-cycle alloc and write on addr 9 -> busy[9]=1 afterwards, mem[9] updated.
- Ignored traffic during CLEAR: i_we to addr 3 data 0xAA and alloc addr 3 in sweep cycle 10 -> after o_ready, addr 3 reads 0, busy 0.
- Reset mid-sweep: reassert i_rst at sweep cycle 20 -> o_ready stays low for a further full 32 cycles after release. No nonzero read data is visible meanwhile.
